// File: rtl/cache_line_fill_ctrl.sv
// Sequences a wrap-around SDRAM burst into the 32-bit byte-enabled cache RAM
// and keeps a per-halfword valid map so the CPU can hit before the burst ends.
module cache_line_fill_ctrl #(
    parameter int AW      = 10,
    parameter int LINE_HW = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   req,
    input  logic [AW-$clog2(LINE_HW/2)-1:0]        req_line,
    input  logic [$clog2(LINE_HW)-1:0]             req_crit,
    output logic                                   ack,
    input  logic                                   abort,
    input  logic                                   sd_valid,
    input  logic [15:0]                            sd_data,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err,
    output logic [LINE_HW-1:0]                     fill_valid,
    output logic                                   ram_wren,
    output logic [3:0]                             ram_byteena,
    output logic [AW-1:0]                          ram_address,
    output logic [31:0]                            ram_data
);

    localparam int HW_W = $clog2(LINE_HW);
    localparam int LN_W = AW - HW_W + 1;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [HW_W-1:0] HW_LAST = HW_W'(LINE_HW - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL, S_DONE} state_t;

    state_t          state;
    logic [LN_W-1:0] line_q;
    logic [HW_W-1:0] crit_q;
    logic [HW_W-1:0] hw_cnt;
    logic [HW_W-1:0] idx;
    logic [TW-1:0]   timer;
    logic [AW-1:0]   word_addr;

    // Halfword index wraps naturally in HW_W bits; dropping its LSB gives the RAM word.
    assign idx       = crit_q + hw_cnt;
    assign word_addr = AW'({line_q, idx} >> 1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            line_q      <= '0;
            crit_q      <= '0;
            hw_cnt      <= '0;
            timer       <= '0;
            ack         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            fill_valid  <= '0;
            ram_wren    <= 1'b0;
            ram_byteena <= 4'b0000;
            ram_address <= '0;
            ram_data    <= 32'h0;
        end else begin
            ack      <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            ram_wren <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state      <= S_WAIT;
                        ack        <= 1'b1;
                        busy       <= 1'b1;
                        line_q     <= req_line;
                        crit_q     <= req_crit;
                        fill_valid <= '0;
                        hw_cnt     <= '0;
                        timer      <= '0;
                    end
                end
                S_WAIT, S_FILL: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        fill_valid <= '0;
                    end else if (sd_valid) begin
                        // Big-endian: even halfword lands in the upper 16 bits.
                        ram_wren        <= 1'b1;
                        ram_address     <= word_addr;
                        ram_data        <= {sd_data, sd_data};
                        ram_byteena     <= idx[0] ? 4'b0011 : 4'b1100;
                        fill_valid[idx] <= 1'b1;
                        hw_cnt          <= hw_cnt + HW_W'(1);
                        timer           <= '0;
                        done            <= (hw_cnt == HW_LAST);
                        state           <= (hw_cnt == HW_LAST) ? S_DONE : S_FILL;
                    end else if (timer == T_LAST) begin
                        state      <= S_IDLE;
                        err        <= 1'b1;
                        busy       <= 1'b0;
                        fill_valid <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                // One extra cycle so a held req cannot be taken in the done cycle.
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Bench for cache_line_fill_ctrl: directed scenarios plus random traffic, all
// compared cycle by cycle against a transaction-level reference model.
module tb_cache_line_fill_ctrl;

    localparam int AW  = 10;
    localparam int LHW = 8;
    localparam int TO  = 4;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            req = 1'b0;
    logic [AW-3:0]   req_line = '0;
    logic [2:0]      req_crit = '0;
    logic            abort = 1'b0;
    logic            sd_valid = 1'b0;
    logic [15:0]     sd_data = '0;
    logic            ack, busy, done, err, ram_wren;
    logic [LHW-1:0]  fill_valid;
    logic [3:0]      ram_byteena;
    logic [AW-1:0]   ram_address;
    logic [31:0]     ram_data;

    int n_chk = 0;
    int n_fail = 0;

    cache_line_fill_ctrl #(.AW(AW), .LINE_HW(LHW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_line(req_line),
        .req_crit(req_crit), .ack(ack), .abort(abort), .sd_valid(sd_valid),
        .sd_data(sd_data), .busy(busy), .done(done), .err(err),
        .fill_valid(fill_valid), .ram_wren(ram_wren), .ram_byteena(ram_byteena),
        .ram_address(ram_address), .ram_data(ram_data)
    );

    always #5 clock = ~clock;

    // Reference model: a fill is "open" while accepting words, "closing" for
    // the single cycle after the last word.
    bit             m_open, m_closing;
    int             m_line, m_crit, m_n, m_idle;
    logic [LHW-1:0] m_fv;
    logic [63:0]    e_vec;

    task automatic model_reset();
        m_open = 0; m_closing = 0; m_n = 0; m_idle = 0; m_fv = '0; e_vec = '0;
    endtask

    function automatic logic [63:0] obs();
        return 64'({ack, busy, done, err, ram_wren,
                    ram_wren ? ram_byteena : 4'h0,
                    ram_wren ? ram_address : 10'h0,
                    ram_wren ? ram_data : 32'h0, fill_valid});
    endfunction

    // Advance the model on the current inputs, then clock the DUT.
    task automatic tick();
        bit            e_ack = 0, e_done = 0, e_err = 0, e_wren = 0;
        logic [3:0]    e_be = '0;
        logic [AW-1:0] e_addr = '0;
        logic [31:0]   e_data = '0;
        int            idx;
        if (m_closing) begin
            m_closing = 0;
        end else if (!m_open) begin
            if (req) begin
                e_ack = 1; m_open = 1; m_line = req_line; m_crit = req_crit;
                m_n = 0; m_idle = 0; m_fv = '0;
            end
        end else if (abort) begin
            m_open = 0; m_fv = '0;
        end else if (sd_valid) begin
            idx    = (m_crit + m_n) % LHW;
            e_wren = 1;
            e_addr = AW'(m_line * (LHW / 2) + idx / 2);
            e_be   = (idx % 2 == 1) ? 4'b0011 : 4'b1100;
            e_data = {sd_data, sd_data};
            m_fv[idx] = 1'b1;
            m_n++; m_idle = 0;
            if (m_n == LHW) begin
                e_done = 1; m_open = 0; m_closing = 1;
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                e_err = 1; m_open = 0; m_fv = '0;
            end
        end
        e_vec = 64'({e_ack, m_open | m_closing, e_done, e_err, e_wren,
                     e_be, e_addr, e_data, m_fv});
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if (obs() !== 64'h0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=0", obs());
        end
        n_chk++;
        if ({ram_address, ram_data, ram_byteena} !== '0) begin
            n_fail++; $display("FAIL reset_ram_bus got=%h/%h/%h exp=0", ram_address, ram_data, ram_byteena);
        end
        #5 reset_n = 1'b1;
        model_reset();
        @(posedge clock); #1;
    endtask

    task automatic test_linear();
        req = 1; req_line = 8'd5; req_crit = 3'd0;
        tick(); req = 0;
        n_chk++;
        if (obs() !== e_vec) begin n_fail++; $display("FAIL linear_ack got=%h exp=%h", obs(), e_vec); end
        for (int c = 0; c < 11; c++) begin
            sd_valid = (c < 8); sd_data = 16'h1000 + 16'(c);
            tick();
            n_chk++;
            if (obs() !== e_vec) begin n_fail++; $display("FAIL linear c=%0d got=%h exp=%h", c, obs(), e_vec); end
        end
        sd_valid = 0;
    endtask

    task automatic test_wrap();
        req = 1; req_line = 8'd5; req_crit = 3'd5;
        tick(); req = 0;
        for (int c = 0; c < 36; c++) begin
            sd_valid = (c % 4 == 3) && (c < 32); sd_data = 16'h00A0 + 16'(c / 4);
            tick();
            n_chk++;
            if (obs() !== e_vec) begin n_fail++; $display("FAIL wrap c=%0d got=%h exp=%h", c, obs(), e_vec); end
        end
        sd_valid = 0;
    endtask

    task automatic test_abort();
        req = 1; req_line = 8'd9; req_crit = 3'd2;
        tick(); req = 0;
        for (int c = 0; c < 8; c++) begin
            sd_valid = (c <= 3); sd_data = 16'(c * 16'h1111);
            abort = (c == 3) || (c == 5);
            tick();
            n_chk++;
            if (obs() !== e_vec) begin n_fail++; $display("FAIL abort c=%0d got=%h exp=%h", c, obs(), e_vec); end
        end
        sd_valid = 0; abort = 0;
    endtask

    task automatic test_timeout();
        req = 1; req_line = 8'd200; req_crit = 3'd7;
        tick(); req = 0;
        for (int c = 0; c < 11; c++) begin
            sd_valid = (c < 2) || (c == 8); sd_data = 16'hBEE0 + 16'(c);
            tick();
            n_chk++;
            if (obs() !== e_vec) begin n_fail++; $display("FAIL timeout c=%0d got=%h exp=%h", c, obs(), e_vec); end
        end
        sd_valid = 0;
    endtask

    task automatic test_back_to_back();
        req = 1; sd_valid = 1; req_line = 8'd33; req_crit = 3'd3;
        for (int c = 0; c < 30; c++) begin
            sd_data = 16'($urandom);
            if (c == 12) begin req_line = 8'd34; req_crit = 3'd6; end
            tick();
            n_chk++;
            if (obs() !== e_vec) begin n_fail++; $display("FAIL b2b c=%0d got=%h exp=%h", c, obs(), e_vec); end
        end
        req = 0; sd_valid = 0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req      = ($urandom_range(0, 3) == 0);
            req_line = 8'($urandom);
            req_crit = 3'($urandom);
            abort    = ($urandom_range(0, 31) == 0);
            sd_valid = ($urandom_range(0, 2) != 0);
            sd_data  = 16'($urandom);
            tick();
            n_chk++;
            if (obs() !== e_vec) begin n_fail++; $display("FAIL random c=%0d got=%h exp=%h", c, obs(), e_vec); end
        end
        req = 0; abort = 0; sd_valid = 0;
        for (int c = 0; c < 12; c++) tick();
        model_reset();
    endtask

    task automatic test_async_reset();
        req = 1; req_line = 8'd3; req_crit = 3'd2;
        tick(); req = 0;
        for (int c = 0; c < 4; c++) begin
            sd_valid = 1; sd_data = 16'hC0DE + 16'(c);
            tick();
            n_chk++;
            if (obs() !== e_vec) begin n_fail++; $display("FAIL arst_pre c=%0d got=%h exp=%h", c, obs(), e_vec); end
        end
        #3 reset_n = 1'b0;
        #1;
        n_chk++;
        if (obs() !== 64'h0) begin n_fail++; $display("FAIL arst_outputs got=%h exp=0", obs()); end
        n_chk++;
        if ({ram_address, ram_data, ram_byteena} !== '0) begin
            n_fail++; $display("FAIL arst_ram_bus got=%h/%h/%h exp=0", ram_address, ram_data, ram_byteena);
        end
        model_reset();
        sd_valid = 1;
        #3 reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if (obs() !== e_vec) begin n_fail++; $display("FAIL arst_post c=%0d got=%h exp=%h", c, obs(), e_vec); end
        end
        sd_valid = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_linear();
        test_wrap();
        test_abort();
        test_timeout();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
